// File: rtl/softmax_pkg.sv
// Shared types and default sizing for the softmax read-side blocks.
package softmax_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int SOFTMAX_DATA_WIDTH = 16;
  localparam int SOFTMAX_NUM_REGS   = 10;
  localparam int SOFTMAX_IDX_W      = 4;

endpackage

// File: rtl/softmax_snapshot_bank.sv
// Snapshot register bank: NUM_REGS words captured together on load, read back through an indexed mux.
module softmax_snapshot_bank
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = SOFTMAX_DATA_WIDTH,
  parameter int NUM_REGS   = SOFTMAX_NUM_REGS,
  parameter int IDX_W      = SOFTMAX_IDX_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] data_in_flat,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data
);

  logic [DATA_WIDTH-1:0] bank_r [NUM_REGS];

  // Capture all words at once so writers may refill the source bank immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_r[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_r[i] <= data_in_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_r[i] <= bank_r[i];
      end
    end
  end

  // Read mux; an out-of-range index returns zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = bank_r[i];
      end else begin
        rd_data = rd_data;
      end
    end
  end

endmodule

// File: rtl/softmax_reg_reader.sv
// Streams a snapshot of the softmax register bank over valid/ready, one word per accepted beat.
// Define SOFTMAX_RD_ARGMAX_EN to build the running signed max / argmax tracker.
module softmax_reg_reader
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = SOFTMAX_DATA_WIDTH,
  parameter int NUM_REGS   = SOFTMAX_NUM_REGS,
  parameter int IDX_W      = SOFTMAX_IDX_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] data_in_flat,
  input  logic                           start,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]               out_idx,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done,
  output logic [DATA_WIDTH-1:0]          max_val,
  output logic [IDX_W-1:0]               argmax_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t                state_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [IDX_W-1:0]      out_idx_r;
  logic                  out_last_r;
  logic                  busy_r;
  logic                  done_r;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  accept_s;
  logic                  bank_load_s;

  assign accept_s    = out_valid_r & out_ready;
  assign bank_load_s = load & (state_r != STREAM);

  // The mux always looks one word ahead so the next beat is ready on accept.
  always_comb begin
    if (state_r == STREAM) begin
      rd_idx_s = out_idx_r + IDX_W'(1);
    end else begin
      rd_idx_s = '0;
    end
  end

  softmax_snapshot_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (bank_load_s),
    .data_in_flat (data_in_flat),
    .rd_idx       (rd_idx_s),
    .rd_data      (rd_data_s)
  );

  // Control FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_idx_r   <= '0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r     <= STREAM;
            out_valid_r <= 1'b1;
            out_idx_r   <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b1;
            // A same-cycle load is not in the bank yet, so word 0 comes straight from the input.
            out_data_r  <= load ? data_in_flat[DATA_WIDTH-1:0] : rd_data_s;
          end
        end
        STREAM: begin
          if (accept_s && out_last_r) begin
            state_r     <= DONE;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end else if (accept_s) begin
            out_idx_r  <= out_idx_r + IDX_W'(1);
            out_data_r <= rd_data_s;
            out_last_r <= ((out_idx_r + IDX_W'(1)) == LAST_IDX);
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

`ifdef SOFTMAX_RD_ARGMAX_EN
  logic [DATA_WIDTH-1:0] max_val_r;
  logic [IDX_W-1:0]      argmax_idx_r;

  // Signed running maximum over accepted beats; strict compare keeps the lower index on ties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_val_r    <= '0;
      argmax_idx_r <= '0;
    end else if (accept_s &&
                 ((out_idx_r == '0) || ($signed(out_data_r) > $signed(max_val_r)))) begin
      max_val_r    <= out_data_r;
      argmax_idx_r <= out_idx_r;
    end else begin
      max_val_r    <= max_val_r;
      argmax_idx_r <= argmax_idx_r;
    end
  end

  assign max_val    = max_val_r;
  assign argmax_idx = argmax_idx_r;
`else
  assign max_val    = '0;
  assign argmax_idx = '0;
`endif

endmodule

// File: tb/tb_softmax_reg_reader.sv
// Directed self-checking bench for softmax_reg_reader; argmax expectations follow SOFTMAX_RD_ARGMAX_EN.
module tb_softmax_reg_reader;

  localparam int DW = 16;
  localparam int NR = 10;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load = 1'b0;
  logic [NR*DW-1:0] data_in_flat = '0;
  logic           start = 1'b0;
  logic           out_ready = 1'b1;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic [IW-1:0]  out_idx;
  logic           out_last;
  logic           busy;
  logic           done;
  logic [DW-1:0]  max_val;
  logic [IW-1:0]  argmax_idx;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] wv [NR];

  softmax_reg_reader #(.DATA_WIDTH(DW), .NUM_REGS(NR), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .data_in_flat (data_in_flat),
    .start        (start),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .max_val      (max_val),
    .argmax_idx   (argmax_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [NR*DW-1:0] pack_wv();
    logic [NR*DW-1:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = wv[i];
    return f;
  endfunction

  // Stimulus helpers: called and returning just after a negedge.
  task automatic do_load();
    load = 1'b1;
    data_in_flat = pack_wv();
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    if ({out_valid, out_last, busy, done, out_data, out_idx, max_val, argmax_idx} !== '0) begin
      $display("FAIL reset_state: got v%b l%b b%b d%b data=%h idx=%0d max=%h arg=%0d want all 0",
               out_valid, out_last, busy, done, out_data, out_idx, max_val, argmax_idx);
      n_bad++;
    end
    n_cmp++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [23:0] got, exp;
    for (int i = 0; i < NR; i++) wv[i] = DW'(i + 1);
    do_load();
    if (out_valid !== 1'b0) begin
      $display("FAIL pre_start_valid: got %b want 0", out_valid); n_bad++;
    end
    n_cmp++;
    do_start();
    for (int i = 0; i < NR; i++) begin
      got = {out_valid, out_idx, out_data, out_last, busy, done};
      exp = {1'b1, IW'(i), DW'(i + 1), (i == NR - 1), 1'b1, 1'b0};
      if (got !== exp) begin
        $display("FAIL stream_beat%0d: got %h want %h", i, got, exp); n_bad++;
      end
      n_cmp++;
      @(negedge clk);
    end
    if ({done, out_valid, busy} !== 3'b100) begin
      $display("FAIL stream_done: got d/v/b=%b want 100", {done, out_valid, busy}); n_bad++;
    end
    n_cmp++;
    @(negedge clk);
    if (done !== 1'b0) begin
      $display("FAIL stream_done_width: got %b want 0", done); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_backpressure();
    do_start();
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if ({out_valid, out_idx, out_data, out_last} !== {1'b1, 4'd4, 16'd5, 1'b0}) begin
        $display("FAIL bp_hold%0d: got v%b idx%0d data%0d l%b want v1 idx4 data5 l0",
                 c, out_valid, out_idx, out_data, out_last); n_bad++;
      end
      n_cmp++;
      if (c < 3) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    if ({out_valid, out_idx, out_data} !== {1'b1, 4'd5, 16'd6}) begin
      $display("FAIL bp_resume: got v%b idx%0d data%0d want v1 idx5 data6",
               out_valid, out_idx, out_data); n_bad++;
    end
    n_cmp++;
    repeat (5) @(negedge clk);
    if (done !== 1'b1) begin
      $display("FAIL bp_done: got %b want 1", done); n_bad++;
    end
    n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_load_in_stream();
    do_start();
    for (int i = 0; i < NR; i++) begin
      if (i == 2) begin
        load = 1'b1;
        data_in_flat = '1;
      end
      if ({out_idx, out_data} !== {IW'(i), DW'(i + 1)}) begin
        $display("FAIL ls_orig%0d: got idx%0d data%h want idx%0d data%h",
                 i, out_idx, out_data, i, i + 1); n_bad++;
      end
      n_cmp++;
      @(negedge clk);
    end
    if (done !== 1'b1) begin
      $display("FAIL ls_done: got %b want 1", done); n_bad++;
    end
    n_cmp++;
    @(negedge clk);
    load = 1'b0;
    do_start();
    for (int i = 0; i < NR; i++) begin
      if ({out_valid, out_idx, out_data} !== {1'b1, IW'(i), 16'hFFFF}) begin
        $display("FAIL ls_new%0d: got v%b idx%0d data%h want v1 idx%0d data ffff",
                 i, out_valid, out_idx, out_data, i); n_bad++;
      end
      n_cmp++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k;
    do_start();
    repeat (6) @(negedge clk);
    if (out_idx !== 4'd6) begin
      $display("FAIL rm_at6: got idx%0d want 6", out_idx); n_bad++;
    end
    n_cmp++;
    rst_n = 1'b0;
    @(negedge clk);
    if ({out_valid, busy, done} !== 3'b000) begin
      $display("FAIL rm_abort: got v/b/d=%b want 000", {out_valid, busy, done}); n_bad++;
    end
    n_cmp++;
    rst_n = 1'b1;
    @(negedge clk);
    if (done !== 1'b0) begin
      $display("FAIL rm_no_done: got %b want 0", done); n_bad++;
    end
    n_cmp++;
    do_start();
    for (int i = 0; i < NR; i++) begin
      if ({out_valid, out_idx, out_data} !== {1'b1, IW'(i), 16'h0000}) begin
        $display("FAIL rm_zero%0d: got v%b idx%0d data%h want v1 idx%0d data 0",
                 i, out_valid, out_idx, out_data, i); n_bad++;
      end
      n_cmp++;
      @(negedge clk);
    end
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    if (done !== 1'b1) begin
      $display("FAIL rm_timeout: got done %b want 1", done); n_bad++;
    end
    n_cmp++;
    @(negedge clk);
  endtask

  task automatic test_start_controls();
    for (int i = 0; i < NR; i++) wv[i] = DW'(i + 1);
    do_load();
    do_start();
    for (int i = 0; i < NR; i++) begin
      start = (i == 3);
      if ({out_idx, out_data} !== {IW'(i), DW'(i + 1)}) begin
        $display("FAIL sb_noreset%0d: got idx%0d data%0d want idx%0d data%0d",
                 i, out_idx, out_data, i, i + 1); n_bad++;
      end
      n_cmp++;
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NR; i++) wv[i] = DW'(100 + i);
    data_in_flat = pack_wv();
    load = 1'b1;
    start = 1'b1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if ({out_valid, out_idx, out_data} !== {1'b1, IW'(i), DW'(100 + i)}) begin
        $display("FAIL ls_same%0d: got v%b idx%0d data%0d want v1 idx%0d data%0d",
                 i, out_valid, out_idx, out_data, i, 100 + i); n_bad++;
      end
      n_cmp++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_argmax(input logic [DW-1:0] exp_max, input logic [IW-1:0] exp_arg);
    logic [DW-1:0] em;
    logic [IW-1:0] ea;
`ifdef SOFTMAX_RD_ARGMAX_EN
    em = exp_max;
    ea = exp_arg;
`else
    em = '0;
    ea = '0;
`endif
    do_load();
    do_start();
    repeat (NR) @(negedge clk);
    if ({done, max_val, argmax_idx} !== {1'b1, em, ea}) begin
      $display("FAIL argmax_done: got d%b max%h arg%0d want d1 max%h arg%0d",
               done, max_val, argmax_idx, em, ea); n_bad++;
    end
    n_cmp++;
    repeat (2) @(negedge clk);
    if ({max_val, argmax_idx} !== {em, ea}) begin
      $display("FAIL argmax_hold: got max%h arg%0d want max%h arg%0d",
               max_val, argmax_idx, em, ea); n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_load_in_stream();
    test_reset_mid();
    test_start_controls();
    wv[0] = 16'd3; wv[1] = -16'sd2; wv[2] = 16'd9; wv[3] = 16'd9;
    for (int i = 4; i < NR; i++) wv[i] = 16'd0;
    test_argmax(16'd9, 4'd2);
    wv[0] = -16'sd5; wv[1] = -16'sd3; wv[2] = -16'sd3; wv[3] = -16'sd8; wv[4] = -16'sd7;
    wv[5] = -16'sd9; wv[6] = -16'sd10; wv[7] = -16'sd6; wv[8] = -16'sd4; wv[9] = -16'sd100;
    test_argmax(16'hFFFD, 4'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
